// File: rtl/gb_lcd_capture_if.sv
// LCD pixel stream in, converter write port out (optional err_count under GB_LCD_CAPTURE_ERR_EN).
// Pure wiring; all timing comes from the capture module.
// No backpressure: the PPU stream cannot be stalled, the converter always accepts writes.
interface gb_lcd_capture_if;
  logic       lcd_valid;
  logic [1:0] lcd_data;
  logic       lcd_hsync;
  logic       lcd_vsync;
  logic [1:0] pixel_data;
  logic [7:0] gb_pixel_count;
  logic [7:0] gb_line_count;
  logic       gb_hsync;
  logic       gb_vsync;
  logic       gb_we;
`ifdef GB_LCD_CAPTURE_ERR_EN
  logic [7:0] err_count;
`endif

  // Capture block: consumes the LCD stream, produces the write port.
  modport master (
    input  lcd_valid, lcd_data, lcd_hsync, lcd_vsync,
    output pixel_data, gb_pixel_count, gb_line_count, gb_hsync, gb_vsync, gb_we
`ifdef GB_LCD_CAPTURE_ERR_EN
    , output err_count
`endif
  );

  // Environment side: PPU source plus converter sink.
  modport slave (
    output lcd_valid, lcd_data, lcd_hsync, lcd_vsync,
    input  pixel_data, gb_pixel_count, gb_line_count, gb_hsync, gb_vsync, gb_we
`ifdef GB_LCD_CAPTURE_ERR_EN
    , input err_count
`endif
  );
endinterface

// File: rtl/gb_lcd_capture.sv
// Game Boy LCD stream capture: tracks x/y, drops malformed lines/frames, writes only inside 160x144.
// Latency: 1 cycle from lcd_valid/syncs to gb_we/gb_hsync/gb_vsync; all outputs registered.
// No backpressure; optional GB_LCD_CAPTURE_ERR_EN adds a saturating err_count.
module gb_lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144
) (
  input  logic              clock,
  input  logic              reset,
  gb_lcd_capture_if.master  bus
);

  localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t     state;
  logic [7:0] x;
  logic [7:0] y;
  logic       last_hsync;
  logic       last_vsync;

  logic vs_rise;
  logic hs_rise;

  assign vs_rise = bus.lcd_vsync & ~last_vsync;
  assign hs_rise = bus.lcd_hsync & ~last_hsync;

  // Position tracking FSM with registered write port; vsync edge wins over everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      x                  <= 8'd0;
      y                  <= 8'd0;
      last_hsync         <= 1'b0;
      last_vsync         <= 1'b0;
      bus.pixel_data     <= 2'd0;
      bus.gb_pixel_count <= 8'd0;
      bus.gb_line_count  <= 8'd0;
      bus.gb_hsync       <= 1'b0;
      bus.gb_vsync       <= 1'b0;
      bus.gb_we          <= 1'b0;
    end else begin
      last_hsync   <= bus.lcd_hsync;
      last_vsync   <= bus.lcd_vsync;
      bus.gb_hsync <= bus.lcd_hsync;
      bus.gb_vsync <= bus.lcd_vsync;
      bus.gb_we    <= 1'b0;

      if (vs_rise) begin
        // New frame: a strobe in the same cycle lands at (0,0).
        state <= ACTIVE;
        y     <= 8'd0;
        if (bus.lcd_valid) begin
          bus.gb_we          <= 1'b1;
          bus.pixel_data     <= bus.lcd_data;
          bus.gb_pixel_count <= 8'd0;
          bus.gb_line_count  <= 8'd0;
          x                  <= 8'd1;
        end else begin
          x <= 8'd0;
        end
      end else begin
        case (state)
          ACTIVE, HBLANK: begin
            if (hs_rise) begin
              // End of line (complete or short): advance y, or park in VBLANK after the last line.
              if (y < Y_LAST) begin
                state <= ACTIVE;
                y     <= y + 8'd1;
                if (bus.lcd_valid) begin
                  bus.gb_we          <= 1'b1;
                  bus.pixel_data     <= bus.lcd_data;
                  bus.gb_pixel_count <= 8'd0;
                  bus.gb_line_count  <= y + 8'd1;
                  x                  <= 8'd1;
                end else begin
                  x <= 8'd0;
                end
              end else begin
                state <= VBLANK;
              end
            end else if (bus.lcd_valid && state == ACTIVE) begin
              bus.gb_we          <= 1'b1;
              bus.pixel_data     <= bus.lcd_data;
              bus.gb_pixel_count <= x;
              bus.gb_line_count  <= y;
              x                  <= x + 8'd1;
              if (x == X_LAST) begin
                state <= HBLANK;
              end
            end
          end
          default: ; // IDLE and VBLANK only leave on a vsync edge
        endcase
      end
    end
  end

`ifdef GB_LCD_CAPTURE_ERR_EN
  logic err_evt;

  // One event per cycle at most: short line, dropped strobe in a blank, or stray hsync in VBLANK.
  always_comb begin
    err_evt = 1'b0;
    if (!vs_rise) begin
      case (state)
        ACTIVE:  err_evt = hs_rise;
        HBLANK:  err_evt = bus.lcd_valid & ~(hs_rise & (y < Y_LAST));
        VBLANK:  err_evt = bus.lcd_valid | hs_rise;
        default: err_evt = 1'b0;
      endcase
    end
  end

  // Saturating error counter, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.err_count <= 8'd0;
    end else if (err_evt && bus.err_count != 8'hFF) begin
      bus.err_count <= bus.err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: reset, idle filtering, full frame, short line,
// coincident syncs, long frame and asynchronous mid-line reset.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_gb_lcd_capture;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  gb_lcd_capture_if bus ();

  gb_lcd_capture #(.H_PIXELS(160), .V_LINES(144)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock of stimulus; returns just after the edge that sampled it.
  task automatic cyc(input logic v, input logic [1:0] d, input logic hs, input logic vs);
    @(negedge clock);
    bus.lcd_valid = v;
    bus.lcd_data  = d;
    bus.lcd_hsync = hs;
    bus.lcd_vsync = vs;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.lcd_valid = 1'b0;
    bus.lcd_data  = 2'd0;
    bus.lcd_hsync = 1'b0;
    bus.lcd_vsync = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data,
         bus.gb_hsync, bus.gb_vsync} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs got we=%b x=%0d y=%0d d=%0d hs=%b vs=%b want all 0",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data,
               bus.gb_hsync, bus.gb_vsync);
    end
`ifdef GB_LCD_CAPTURE_ERR_EN
    total++;
    if (bus.err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_err got %0d want 0", bus.err_count);
    end
`endif
  endtask

  task automatic test_idle_ignore();
    int writes;
    do_reset();
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 2'(i), 1'b0, 1'b0);
      if (bus.gb_we) writes++;
      if (i == 7) cyc(1'b0, 2'd0, 1'b1, 1'b0);
    end
    total++;
    if (writes !== 0) begin
      bad++;
      $display("FAIL idle_writes got %0d want 0", writes);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    total++;
    if (bus.gb_we !== 1'b0) begin
      bad++;
      $display("FAIL idle_vs_cycle_we got %b want 0", bus.gb_we);
    end
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data} !== {1'b1, 8'd0, 8'd0, 2'b11}) begin
      bad++;
      $display("FAIL first_write got we=%b x=%0d y=%0d d=%0d want we=1 x=0 y=0 d=3",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    total++;
    if ({bus.gb_we, bus.pixel_data} !== {1'b0, 2'b11}) begin
      bad++;
      $display("FAIL we_pulse_hold got we=%b d=%0d want we=0 d=3", bus.gb_we, bus.pixel_data);
    end
  endtask

  task automatic test_full_frame_and_long_frame();
    int writes;
    int wrong;
    int stray;
    do_reset();
    writes = 0;
    wrong  = 0;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int yy = 0; yy < 144; yy++) begin
      if (yy > 0) cyc(1'b0, 2'd0, 1'b1, 1'b0);
      for (int xx = 0; xx < 160; xx++) begin
        cyc(1'b1, 2'(xx + yy), 1'b0, 1'b0);
        if (bus.gb_we) writes++;
        if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data} !==
            {1'b1, 8'(xx), 8'(yy), 2'(xx + yy)}) begin
          wrong++;
          if (wrong < 4)
            $display("FAIL frame_pixel at x=%0d y=%0d got we=%b x=%0d y=%0d d=%0d",
                     xx, yy, bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data);
        end
      end
    end
    total++;
    if (wrong !== 0) begin
      bad++;
      $display("FAIL frame_pixels got %0d wrong want 0", wrong);
    end
    total++;
    if (writes !== 23040) begin
      bad++;
      $display("FAIL frame_write_count got %0d want 23040", writes);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count} !== {1'b0, 8'd159, 8'd143}) begin
      bad++;
      $display("FAIL frame_last got we=%b x=%0d y=%0d want we=0 x=159 y=143",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count);
    end
    // Seven more hsync edges: one closes line 143, six fall into VBLANK.
    stray = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 2'd0, 1'b1, 1'b0);
      if (bus.gb_we) stray++;
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 2'd1, 1'b0, 1'b0);
      if (bus.gb_we) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL long_frame_writes got %0d want 0", stray);
    end
    total++;
    if ({bus.gb_pixel_count, bus.gb_line_count} !== {8'd159, 8'd143}) begin
      bad++;
      $display("FAIL long_frame_hold got x=%0d y=%0d want x=159 y=143",
               bus.gb_pixel_count, bus.gb_line_count);
    end
`ifdef GB_LCD_CAPTURE_ERR_EN
    // 6 stray hsync edges + 10 dropped strobes so far.
    total++;
    if (bus.err_count !== 8'd16) begin
      bad++;
      $display("FAIL err_long_frame got %0d want 16", bus.err_count);
    end
    for (int k = 0; k < 250; k++) cyc(1'b1, 2'd0, 1'b0, 1'b0);
    total++;
    if (bus.err_count !== 8'd255) begin
      bad++;
      $display("FAIL err_saturate got %0d want 255", bus.err_count);
    end
`endif
  endtask

  task automatic test_short_line();
    int wrong;
    do_reset();
    wrong = 0;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int yy = 0; yy < 6; yy++) begin
      if (yy > 0) cyc(1'b0, 2'd0, 1'b1, 1'b0);
      for (int xx = 0; xx < ((yy == 5) ? 100 : 160); xx++) begin
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count} !== {1'b1, 8'(xx), 8'(yy)}) wrong++;
      end
    end
    total++;
    if (wrong !== 0) begin
      bad++;
      $display("FAIL short_line_pixels got %0d wrong want 0", wrong);
    end
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    total++;
    if (bus.gb_we !== 1'b0) begin
      bad++;
      $display("FAIL short_line_pad got we=%b want 0", bus.gb_we);
    end
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data} !== {1'b1, 8'd0, 8'd6, 2'd1}) begin
      bad++;
      $display("FAIL short_line_next got we=%b x=%0d y=%0d d=%0d want we=1 x=0 y=6 d=1",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data);
    end
`ifdef GB_LCD_CAPTURE_ERR_EN
    total++;
    if (bus.err_count !== 8'd1) begin
      bad++;
      $display("FAIL err_short_line got %0d want 1", bus.err_count);
    end
`endif
  endtask

  task automatic test_vs_hs_same_cycle();
    int wrong;
    do_reset();
    wrong = 0;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    // Strobe coinciding with each hsync edge lands at x=0 of the new line.
    for (int yy = 1; yy <= 70; yy++) begin
      cyc(1'b1, 2'd2, 1'b1, 1'b0);
      if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count} !== {1'b1, 8'd0, 8'(yy)}) wrong++;
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
    end
    total++;
    if (wrong !== 0) begin
      bad++;
      $display("FAIL edge_strobe_lines got %0d wrong want 0", wrong);
    end
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    total++;
    if ({bus.gb_pixel_count, bus.gb_line_count} !== {8'd1, 8'd70}) begin
      bad++;
      $display("FAIL edge_strobe_x1 got x=%0d y=%0d want x=1 y=70", bus.gb_pixel_count, bus.gb_line_count);
    end
    cyc(1'b1, 2'd2, 1'b1, 1'b1);
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data, bus.gb_vsync, bus.gb_hsync} !==
        {1'b1, 8'd0, 8'd0, 2'd2, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL vs_hs_same got we=%b x=%0d y=%0d d=%0d gvs=%b ghs=%b want 1 0 0 2 1 1",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data, bus.gb_vsync, bus.gb_hsync);
    end
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.gb_vsync} !== {1'b1, 8'd1, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL vs_hs_next got we=%b x=%0d y=%0d gvs=%b want 1 1 0 0",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.gb_vsync);
    end
  endtask

  task automatic test_reset_mid_line();
    int stray;
    do_reset();
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    for (int yy = 1; yy <= 40; yy++) begin
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
    end
    for (int xx = 1; xx <= 80; xx++) cyc(1'b1, 2'd3, 1'b0, 1'b0);
    total++;
    if ({bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data} !== {8'd80, 8'd40, 2'd3}) begin
      bad++;
      $display("FAIL pre_reset_pos got x=%0d y=%0d d=%0d want x=80 y=40 d=3",
               bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data);
    end
    @(negedge clock);
    bus.lcd_valid = 1'b1;
    bus.lcd_hsync = 1'b1;
    bus.lcd_vsync = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data,
         bus.gb_hsync, bus.gb_vsync} !== 21'd0) begin
      bad++;
      $display("FAIL async_reset got we=%b x=%0d y=%0d d=%0d want all 0",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data);
    end
    @(negedge clock);
    bus.lcd_valid = 1'b0;
    bus.lcd_hsync = 1'b0;
    bus.lcd_vsync = 1'b0;
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 2'd1, 1'b0, 1'b0);
      if (bus.gb_we) stray++;
      cyc(1'b0, 2'd0, 1'b1, 1'b0);
      if (bus.gb_we) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL post_reset_writes got %0d want 0", stray);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    total++;
    if ({bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data} !== {1'b1, 8'd0, 8'd0, 2'd2}) begin
      bad++;
      $display("FAIL restart_write got we=%b x=%0d y=%0d d=%0d want 1 0 0 2",
               bus.gb_we, bus.gb_pixel_count, bus.gb_line_count, bus.pixel_data);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.lcd_valid = 1'b0;
    bus.lcd_data  = 2'd0;
    bus.lcd_hsync = 1'b0;
    bus.lcd_vsync = 1'b0;
    test_reset();
    test_idle_ignore();
    test_full_frame_and_long_frame();
    test_short_line();
    test_vs_hs_same_cycle();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
